// File: rtl/blob_pkg.sv
// Shared geometry and feeder state encoding for the blob feeder and blob counter.
// Pure definitions: no latency, no flow control.
package blob_pkg;

  localparam int IMG_COL = 640;
  localparam int IMG_ROW = 480;
  localparam int NPIX    = IMG_COL * IMG_ROW;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_CAPTURE,
    ST_REPLAY,
    ST_WAIT_DONE
  } feeder_state_t;

  // Inclusive unsigned binarisation of a grayscale sample.
  function automatic logic bin_pix(input logic [7:0] gray, input logic [7:0] thr);
    return (gray >= thr);
  endfunction

endpackage

// File: rtl/blob_frame_feeder_if.sv
// Camera-side, control and replay-side signals of the blob frame feeder.
// Wires only: no latency, no flow control of its own.
interface blob_frame_feeder_if;

  logic       i_start;
  logic [7:0] i_thresh;
  logic       i_sof;
  logic       i_pix_valid;
  logic [7:0] i_gray;
  logic       i_blob_done;
  logic       o_valid;
  logic       o_seq;
  logic       o_busy;
  logic       o_frame_err;

  modport master (
    output i_start, i_thresh, i_sof, i_pix_valid, i_gray, i_blob_done,
    input  o_valid, o_seq, o_busy, o_frame_err
  );

  modport slave (
    input  i_start, i_thresh, i_sof, i_pix_valid, i_gray, i_blob_done,
    output o_valid, o_seq, o_busy, o_frame_err
  );

endinterface

// File: rtl/blob_bit_ram.sv
// Simple dual-port 1-bit frame store, one write and one read port per clock.
// Registered read, 1-cycle latency; always ready, no backpressure.
module blob_bit_ram
  import blob_pkg::*;
#(
  parameter int DEPTH  = NPIX,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic              i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic              o_rdata
);

  // No reset on the array or read register so the store maps onto block RAM.
  logic r_mem [DEPTH];
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/blob_frame_feeder.sv
// Thresholds one camera frame into a bit RAM, then replays it as a gap-free NPIX-cycle burst.
// Burst starts 2 cycles after REPLAY entry; busy until the blob counter reports done, new starts dropped.
module blob_frame_feeder #(
  parameter int IMG_COL = blob_pkg::IMG_COL,
  parameter int IMG_ROW = blob_pkg::IMG_ROW
) (
  input  logic                i_clk,
  input  logic                i_rst,
  blob_frame_feeder_if.slave  io_ff
);

  import blob_pkg::*;

  localparam int NPIX   = IMG_COL * IMG_ROW;
  localparam int ADDR_W = $clog2(NPIX);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  feeder_state_t     r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [ADDR_W-1:0] r_raddr, w_raddr_nxt;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [7:0]        r_thr;
  logic              w_thr_ld;
  logic              w_wr_en;
  logic              w_wr_bit;
  logic              w_rd_en;
  logic              w_rdata;
  logic              w_frame_err;
  logic              r_rd_vld;
  logic              r_valid;
  logic              r_seq;
  logic              r_frame_err;

  always_comb begin
    w_state_nxt = r_state;
    w_waddr_nxt = r_waddr;
    w_raddr_nxt = r_raddr;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_waddr;
    w_wr_bit    = bin_pix(io_ff.i_gray, r_thr);
    w_thr_ld    = 1'b0;
    w_rd_en     = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (io_ff.i_start) begin
          w_state_nxt = ST_WAIT_SOF;
        end
      end
      ST_WAIT_SOF, ST_CAPTURE: begin
        // A pixel coincident with SOF is pixel 0 and uses the freshly presented threshold.
        if (io_ff.i_sof) begin
          w_thr_ld    = 1'b1;
          w_wr_addr   = '0;
          w_wr_bit    = bin_pix(io_ff.i_gray, io_ff.i_thresh);
          w_waddr_nxt = '0;
          w_state_nxt = ST_CAPTURE;
          w_frame_err = (r_state == ST_CAPTURE);
          w_wr_en     = io_ff.i_pix_valid;
        end else if (r_state == ST_CAPTURE) begin
          w_wr_en = io_ff.i_pix_valid;
        end
        if (w_wr_en) begin
          if (w_wr_addr == LAST_ADDR) begin
            w_waddr_nxt = '0;
            w_state_nxt = ST_REPLAY;
          end else begin
            w_waddr_nxt = w_wr_addr + 1'b1;
          end
        end
      end
      ST_REPLAY: begin
        w_rd_en = 1'b1;
        if (r_raddr == LAST_ADDR) begin
          w_raddr_nxt = '0;
          w_state_nxt = ST_WAIT_DONE;
        end else begin
          w_raddr_nxt = r_raddr + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (io_ff.i_blob_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_thr       <= '0;
      r_rd_vld    <= 1'b0;
      r_valid     <= 1'b0;
      r_seq       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_waddr     <= w_waddr_nxt;
      r_raddr     <= w_raddr_nxt;
      r_rd_vld    <= w_rd_en;
      r_valid     <= r_rd_vld;
      r_seq       <= r_rd_vld & w_rdata;
      r_frame_err <= w_frame_err;
      if (w_thr_ld) begin
        r_thr <= io_ff.i_thresh;
      end
    end
  end

  blob_bit_ram #(
    .DEPTH  (NPIX),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (w_wr_addr),
    .i_wdata (w_wr_bit),
    .i_re    (w_rd_en),
    .i_raddr (r_raddr),
    .o_rdata (w_rdata)
  );

  assign io_ff.o_valid     = r_valid;
  assign io_ff.o_seq       = r_seq;
  assign io_ff.o_busy      = (r_state != ST_IDLE);
  assign io_ff.o_frame_err = r_frame_err;

endmodule

// File: tb/tb_blob_frame_feeder.sv
// Directed-random bench for blob_frame_feeder on an 8x4 frame; expected bits come from a frame array model.
module tb_blob_frame_feeder;

  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int NP   = COLS * ROWS;

  logic i_clk = 1'b0;
  logic i_rst;

  always #5 i_clk = ~i_clk;

  blob_frame_feeder_if ff_if ();

  blob_frame_feeder #(
    .IMG_COL (COLS),
    .IMG_ROW (ROWS)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .io_ff (ff_if)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  int         err_cnt     = 0;
  int         widx        = 0;
  logic [7:0] cur_thr     = '0;
  bit         exp_bits [NP];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
    if (ff_if.o_frame_err === 1'b1) err_cnt++;
  endtask

  task automatic start_cmd();
    ff_if.i_start = 1'b1;
    step();
    ff_if.i_start = 1'b0;
  endtask

  task automatic sof(input logic [7:0] thr, input bit with_pix, input logic [7:0] g);
    ff_if.i_sof       = 1'b1;
    ff_if.i_thresh    = thr;
    ff_if.i_pix_valid = with_pix;
    ff_if.i_gray      = g;
    cur_thr = thr;
    widx    = 0;
    if (with_pix) begin
      exp_bits[0] = (g >= thr);
      widx = 1;
    end
    step();
    ff_if.i_sof       = 1'b0;
    ff_if.i_pix_valid = 1'b0;
  endtask

  task automatic pix(input logic [7:0] g, input int gap);
    repeat (gap) step();
    ff_if.i_pix_valid = 1'b1;
    ff_if.i_gray      = g;
    if (widx < NP) exp_bits[widx] = (g >= cur_thr);
    widx++;
    step();
    ff_if.i_pix_valid = 1'b0;
    ff_if.i_gray      = 8'($urandom);
  endtask

  task automatic rand_pixels(input int n);
    for (int k = 0; k < n; k++) pix(8'($urandom), int'($urandom_range(0, 2)));
  endtask

  // Check one replay burst; optional start/SOF injection or reset at a given pixel index.
  task automatic check_burst(input string tag, input int start_at, input int sof_at, input int rst_at);
    int n = 0;
    while (ff_if.o_valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd2);
    for (int i = 0; i < NP; i++) begin
      chk({tag, "_valid"}, 32'(ff_if.o_valid), 32'd1);
      chk({tag, "_seq"}, 32'(ff_if.o_seq), 32'(exp_bits[i]));
      if (i == rst_at) begin
        i_rst = 1'b1;
        #1;
        chk({tag, "_rst_valid"}, 32'(ff_if.o_valid), 32'd0);
        chk({tag, "_rst_busy"}, 32'(ff_if.o_busy), 32'd0);
        return;
      end
      ff_if.i_start     = (i == start_at);
      ff_if.i_sof       = (i == sof_at);
      ff_if.i_pix_valid = (i == sof_at);
      step();
    end
    ff_if.i_start     = 1'b0;
    ff_if.i_sof       = 1'b0;
    ff_if.i_pix_valid = 1'b0;
    chk({tag, "_end_valid"}, 32'(ff_if.o_valid), 32'd0);
  endtask

  task automatic done_pulse();
    ff_if.i_blob_done = 1'b1;
    step();
    ff_if.i_blob_done = 1'b0;
  endtask

  initial begin
    ff_if.i_start     = 1'b0;
    ff_if.i_thresh    = '0;
    ff_if.i_sof       = 1'b0;
    ff_if.i_pix_valid = 1'b0;
    ff_if.i_gray      = '0;
    ff_if.i_blob_done = 1'b0;
    i_rst = 1'b1;
    repeat (3) step();
    chk("rst_valid", 32'(ff_if.o_valid), 32'd0);
    chk("rst_seq", 32'(ff_if.o_seq), 32'd0);
    chk("rst_busy", 32'(ff_if.o_busy), 32'd0);
    chk("rst_frame_err", 32'(ff_if.o_frame_err), 32'd0);
    i_rst = 1'b0;
    step();
    chk("idle_busy", 32'(ff_if.o_busy), 32'd0);

    // Basic frame: alternating 200/50, one idle cycle per pixel; start and SOF injected during replay.
    err_cnt = 0;
    start_cmd();
    chk("t1_busy", 32'(ff_if.o_busy), 32'd1);
    sof(8'd128, 1'b0, 8'd0);
    for (int i = 0; i < NP; i++) pix((i % 2 == 0) ? 8'd200 : 8'd50, 1);
    check_burst("t1", 4, 6, -1);
    chk("t1_no_frame_err", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t1_hold_valid", 32'(ff_if.o_valid), 32'd0);
    end
    chk("t1_hold_busy", 32'(ff_if.o_busy), 32'd1);
    done_pulse();
    chk("t1_done_busy", 32'(ff_if.o_busy), 32'd0);

    // Threshold boundary with pixel 0 on SOF; threshold changes and a start arrive mid-capture.
    start_cmd();
    chk("t2_busy", 32'(ff_if.o_busy), 32'd1);
    sof(8'd128, 1'b1, 8'd127);
    pix(8'd128, 0);
    pix(8'd129, int'($urandom_range(0, 2)));
    rand_pixels(9);
    ff_if.i_thresh = 8'($urandom_range(0, 255));
    ff_if.i_start  = 1'b1;
    step();
    ff_if.i_start  = 1'b0;
    rand_pixels(9);
    ff_if.i_thresh = 8'($urandom_range(0, 255));
    rand_pixels(NP - 21);
    check_burst("t2", -1, -1, -1);
    repeat (3) step();
    ff_if.i_blob_done = 1'b1;
    ff_if.i_start     = 1'b1;
    step();
    ff_if.i_blob_done = 1'b0;
    ff_if.i_start     = 1'b0;
    chk("t2_done_start_busy", 32'(ff_if.o_busy), 32'd0);
    step();
    chk("t2_start_dropped", 32'(ff_if.o_busy), 32'd0);

    // Short frame: 20 all-ones pixels, then a new SOF restarts capture.
    start_cmd();
    err_cnt = 0;
    sof(8'($urandom_range(0, 255)), 1'b0, 8'd0);
    for (int i = 0; i < 20; i++) pix(8'd255, int'($urandom_range(0, 2)));
    chk("t3_err_before", 32'(err_cnt), 32'd0);
    sof(8'($urandom_range(64, 192)), 1'b1, 8'($urandom));
    chk("t3_err_pulse", 32'(err_cnt), 32'd1);
    rand_pixels(NP - 1);
    check_burst("t3", -1, -1, -1);
    chk("t3_err_once", 32'(err_cnt), 32'd1);
    done_pulse();

    // Reset at burst pixel 10, then a full new frame.
    start_cmd();
    sof(8'($urandom_range(0, 255)), 1'b0, 8'd0);
    rand_pixels(NP);
    check_burst("t4", -1, -1, 10);
    step();
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_post_rst_valid", 32'(ff_if.o_valid), 32'd0);
    end
    chk("t4_post_rst_busy", 32'(ff_if.o_busy), 32'd0);
    start_cmd();
    sof(8'($urandom_range(0, 255)), 1'b1, 8'($urandom));
    rand_pixels(NP - 1);
    check_burst("t5", -1, -1, -1);
    done_pulse();
    chk("t5_done_busy", 32'(ff_if.o_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
